// File: rtl/fust_param_table_pkg.sv
// Shared constants for the parametrised functional-unit status table.
// Row field widths default to the original 3-FU, 32-register scalar table.
package fust_param_table_pkg;

    localparam int unsigned DEF_NUM_FU = 3;
    localparam int unsigned DEF_REG_W  = 5;
    localparam int unsigned DEF_TAG_W  = $clog2(DEF_NUM_FU + 1);

    // Tag value meaning "operand already available"; tag k names FU k-1.
    localparam int unsigned TAG_READY  = 0;

endpackage

// File: rtl/fust_param_table_row.sv
// One FUST row: holds busy/issued/spec flags, register fields and producer tags,
// and applies squash, release, dispatch, issue, wakeup and resolve in priority order.
module fust_param_row
    import fust_param_table_pkg::*;
#(
    parameter int unsigned REG_W = DEF_REG_W,
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             disp_we,
    input  logic [REG_W-1:0] disp_rd,
    input  logic [REG_W-1:0] disp_rs1,
    input  logic [REG_W-1:0] disp_rs2,
    input  logic [TAG_W-1:0] disp_t1,
    input  logic [TAG_W-1:0] disp_t2,
    input  logic             disp_spec,
    input  logic             issue_sel,
    input  logic             wb_en,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             done_sel,
    input  logic             resolved,
    input  logic             flush,
    output logic             busy,
    output logic             ready,
    output logic [REG_W-1:0] rd,
    output logic [REG_W-1:0] rs1,
    output logic [REG_W-1:0] rs2,
    output logic [TAG_W-1:0] t1,
    output logic [TAG_W-1:0] t2
);

    logic issued;
    logic spec;
    logic wake_live;
    logic [TAG_W-1:0] new_t1;
    logic [TAG_W-1:0] new_t2;

    assign wake_live = wb_en && (wb_tag != TAG_W'(TAG_READY));
    assign ready     = busy && !issued && (t1 == TAG_W'(TAG_READY)) && (t2 == TAG_W'(TAG_READY));

    // Dispatch bypass: a tag broadcast in the dispatch cycle must not be missed.
    assign new_t1 = (wake_live && (disp_t1 == wb_tag)) ? TAG_W'(TAG_READY) : disp_t1;
    assign new_t2 = (wake_live && (disp_t2 == wb_tag)) ? TAG_W'(TAG_READY) : disp_t2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            issued <= 1'b0;
            spec   <= 1'b0;
            rd     <= '0;
            rs1    <= '0;
            rs2    <= '0;
            t1     <= '0;
            t2     <= '0;
        end else if ((flush && spec) || done_sel) begin
            busy   <= 1'b0;
            issued <= 1'b0;
            spec   <= 1'b0;
            rd     <= '0;
            rs1    <= '0;
            rs2    <= '0;
            t1     <= '0;
            t2     <= '0;
        end else if (disp_we) begin
            busy   <= 1'b1;
            issued <= 1'b0;
            spec   <= disp_spec;
            rd     <= disp_rd;
            rs1    <= disp_rs1;
            rs2    <= disp_rs2;
            t1     <= new_t1;
            t2     <= new_t2;
        end else begin
            if (issue_sel && ready) begin
                issued <= 1'b1;
            end
            if (busy && wake_live && (t1 == wb_tag)) begin
                t1 <= TAG_W'(TAG_READY);
            end
            if (busy && wake_live && (t2 == wb_tag)) begin
                t2 <= TAG_W'(TAG_READY);
            end
            if (resolved && !flush) begin
                spec <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fust_param_table.sv
// Parametrised functional-unit status table: NUM_FU rows between dispatch and issue,
// with combinational dispatch acceptance, ready vector and busy-row count.
module fust_param_table
    import fust_param_table_pkg::*;
#(
    parameter int unsigned NUM_FU = DEF_NUM_FU,
    parameter int unsigned REG_W  = DEF_REG_W,
    parameter int unsigned TAG_W  = $clog2(NUM_FU + 1),
    parameter int unsigned FU_W   = $clog2(NUM_FU)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    disp_en,
    input  logic [FU_W-1:0]         disp_fu,
    input  logic [REG_W-1:0]        disp_rd,
    input  logic [REG_W-1:0]        disp_rs1,
    input  logic [REG_W-1:0]        disp_rs2,
    input  logic [TAG_W-1:0]        disp_t1,
    input  logic [TAG_W-1:0]        disp_t2,
    input  logic                    disp_spec,
    output logic                    disp_ok,
    input  logic                    issue_en,
    input  logic [FU_W-1:0]         issue_fu,
    input  logic                    wb_en,
    input  logic [TAG_W-1:0]        wb_tag,
    input  logic                    done_en,
    input  logic [FU_W-1:0]         done_fu,
    input  logic                    resolved,
    input  logic                    flush,
    output logic [NUM_FU-1:0]       row_busy,
    output logic [NUM_FU-1:0]       row_ready,
    output logic [NUM_FU*REG_W-1:0] row_rd,
    output logic [NUM_FU*TAG_W-1:0] row_t1,
    output logic [NUM_FU*TAG_W-1:0] row_t2,
    output logic [FU_W:0]           occupancy
);

    logic                    target_busy;
    logic                    target_valid;
    logic [NUM_FU*REG_W-1:0] row_rs1;
    logic [NUM_FU*REG_W-1:0] row_rs2;

    assign target_valid = 32'(disp_fu) < NUM_FU;

    always_comb begin
        target_busy = 1'b0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (disp_fu == FU_W'(i)) begin
                target_busy = row_busy[i];
            end
        end
    end

    // A row released this cycle still reads busy here, so no same-cycle re-dispatch.
    assign disp_ok = target_valid && !target_busy && !flush;

    genvar g;
    generate
        for (g = 0; g < NUM_FU; g++) begin : g_row
            fust_param_row #(
                .REG_W (REG_W),
                .TAG_W (TAG_W)
            ) u_row (
                .clk       (CLK),
                .rst_n     (nRST),
                .disp_we   (disp_en && disp_ok && (disp_fu == FU_W'(g))),
                .disp_rd   (disp_rd),
                .disp_rs1  (disp_rs1),
                .disp_rs2  (disp_rs2),
                .disp_t1   (disp_t1),
                .disp_t2   (disp_t2),
                .disp_spec (disp_spec),
                .issue_sel (issue_en && (issue_fu == FU_W'(g))),
                .wb_en     (wb_en),
                .wb_tag    (wb_tag),
                .done_sel  (done_en && (done_fu == FU_W'(g))),
                .resolved  (resolved),
                .flush     (flush),
                .busy      (row_busy[g]),
                .ready     (row_ready[g]),
                .rd        (row_rd[g*REG_W +: REG_W]),
                .rs1       (row_rs1[g*REG_W +: REG_W]),
                .rs2       (row_rs2[g*REG_W +: REG_W]),
                .t1        (row_t1[g*TAG_W +: TAG_W]),
                .t2        (row_t2[g*TAG_W +: TAG_W])
            );
        end
    endgenerate

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            occupancy = occupancy + (FU_W+1)'(row_busy[i]);
        end
    end

endmodule

// File: tb/tb_fust_param_table.sv
// Directed bench for fust_param_table: table-level reference model compared every
// cycle, plus hand-computed literal expectations at key points.
module tb_fust_param_table;

    localparam int N     = 3;
    localparam int REG_W = 5;
    localparam int TAG_W = 2;
    localparam int FU_W  = 2;

    logic                   CLK = 1'b0;
    logic                   nRST = 1'b0;
    logic                   disp_en = 1'b0;
    logic [FU_W-1:0]        disp_fu = '0;
    logic [REG_W-1:0]       disp_rd = '0;
    logic [REG_W-1:0]       disp_rs1 = '0;
    logic [REG_W-1:0]       disp_rs2 = '0;
    logic [TAG_W-1:0]       disp_t1 = '0;
    logic [TAG_W-1:0]       disp_t2 = '0;
    logic                   disp_spec = 1'b0;
    logic                   disp_ok;
    logic                   issue_en = 1'b0;
    logic [FU_W-1:0]        issue_fu = '0;
    logic                   wb_en = 1'b0;
    logic [TAG_W-1:0]       wb_tag = '0;
    logic                   done_en = 1'b0;
    logic [FU_W-1:0]        done_fu = '0;
    logic                   resolved = 1'b0;
    logic                   flush = 1'b0;
    logic [N-1:0]           row_busy;
    logic [N-1:0]           row_ready;
    logic [N*REG_W-1:0]     row_rd;
    logic [N*TAG_W-1:0]     row_t1;
    logic [N*TAG_W-1:0]     row_t2;
    logic [FU_W:0]          occupancy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    fust_param_table #(
        .NUM_FU (N),
        .REG_W  (REG_W),
        .TAG_W  (TAG_W),
        .FU_W   (FU_W)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .disp_en   (disp_en),
        .disp_fu   (disp_fu),
        .disp_rd   (disp_rd),
        .disp_rs1  (disp_rs1),
        .disp_rs2  (disp_rs2),
        .disp_t1   (disp_t1),
        .disp_t2   (disp_t2),
        .disp_spec (disp_spec),
        .disp_ok   (disp_ok),
        .issue_en  (issue_en),
        .issue_fu  (issue_fu),
        .wb_en     (wb_en),
        .wb_tag    (wb_tag),
        .done_en   (done_en),
        .done_fu   (done_fu),
        .resolved  (resolved),
        .flush     (flush),
        .row_busy  (row_busy),
        .row_ready (row_ready),
        .row_rd    (row_rd),
        .row_t1    (row_t1),
        .row_t2    (row_t2),
        .occupancy (occupancy)
    );

    always #5 CLK = ~CLK;

    // Reference table: one record per FU, plain ints.
    int m_busy [N] = '{default: 0};
    int m_iss  [N] = '{default: 0};
    int m_spec [N] = '{default: 0};
    int m_rd   [N] = '{default: 0};
    int m_t1   [N] = '{default: 0};
    int m_t2   [N] = '{default: 0};

    function automatic bit model_ok();
        if (int'(disp_fu) >= N) return 1'b0;
        if (flush) return 1'b0;
        return m_busy[disp_fu] == 0;
    endfunction

    function automatic bit model_ready(int r);
        return m_busy[r] != 0 && m_iss[r] == 0 && m_t1[r] == 0 && m_t2[r] == 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Events applied lowest priority first so higher-priority ones overwrite.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < N; r++) begin
                m_busy[r] <= 0; m_iss[r] <= 0; m_spec[r] <= 0;
                m_rd[r] <= 0; m_t1[r] <= 0; m_t2[r] <= 0;
            end
        end else begin : upd
            int b[N], s[N], sp[N], d[N], a[N], c[N];
            bit ok;
            ok = disp_en && model_ok();
            for (int r = 0; r < N; r++) begin
                b[r] = m_busy[r]; s[r] = m_iss[r]; sp[r] = m_spec[r];
                d[r] = m_rd[r]; a[r] = m_t1[r]; c[r] = m_t2[r];
            end
            if (issue_en && int'(issue_fu) < N && model_ready(int'(issue_fu)))
                s[issue_fu] = 1;
            if (wb_en && wb_tag != 0)
                for (int r = 0; r < N; r++)
                    if (b[r] != 0) begin
                        if (a[r] == int'(wb_tag)) a[r] = 0;
                        if (c[r] == int'(wb_tag)) c[r] = 0;
                    end
            if (resolved && !flush)
                for (int r = 0; r < N; r++) sp[r] = 0;
            if (ok) begin
                b[disp_fu] = 1; s[disp_fu] = 0; sp[disp_fu] = int'(disp_spec);
                d[disp_fu] = int'(disp_rd);
                a[disp_fu] = (wb_en && wb_tag != 0 && disp_t1 == wb_tag) ? 0 : int'(disp_t1);
                c[disp_fu] = (wb_en && wb_tag != 0 && disp_t2 == wb_tag) ? 0 : int'(disp_t2);
            end
            for (int r = 0; r < N; r++) begin
                if ((done_en && int'(done_fu) == r) || (flush && m_spec[r] != 0)) begin
                    b[r] = 0; s[r] = 0; sp[r] = 0; d[r] = 0; a[r] = 0; c[r] = 0;
                end
            end
            for (int r = 0; r < N; r++) begin
                m_busy[r] <= b[r]; m_iss[r] <= s[r]; m_spec[r] <= sp[r];
                m_rd[r] <= d[r]; m_t1[r] <= a[r]; m_t2[r] <= c[r];
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin : cmp
            logic [N-1:0]       eb, er;
            logic [N*REG_W-1:0] erd;
            logic [N*TAG_W-1:0] e1, e2;
            int                 occ;
            occ = 0;
            for (int r = 0; r < N; r++) begin
                eb[r] = m_busy[r] != 0;
                er[r] = model_ready(r);
                erd[r*REG_W +: REG_W] = REG_W'(m_rd[r]);
                e1[r*TAG_W +: TAG_W]  = TAG_W'(m_t1[r]);
                e2[r*TAG_W +: TAG_W]  = TAG_W'(m_t2[r]);
                occ += m_busy[r];
            end
            check("row_busy", 32'(row_busy), 32'(eb));
            check("row_ready", 32'(row_ready), 32'(er));
            check("row_rd", 32'(row_rd), 32'(erd));
            check("row_t1", 32'(row_t1), 32'(e1));
            check("row_t2", 32'(row_t2), 32'(e2));
            check("occupancy", 32'(occupancy), occ);
            check("disp_ok", 32'(disp_ok), 32'(model_ok()));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
        disp_en = 0; issue_en = 0; wb_en = 0; done_en = 0; resolved = 0; flush = 0;
    endtask

    task automatic disp(input int fu, input int rd, input int t1, input int t2, input bit sp);
        disp_en = 1; disp_fu = FU_W'(fu); disp_rd = REG_W'(rd);
        disp_rs1 = REG_W'(rd + 1); disp_rs2 = REG_W'(rd + 2);
        disp_t1 = TAG_W'(t1); disp_t2 = TAG_W'(t2); disp_spec = sp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #2 nRST = 1;
        chk_en = 1;
        #1;
        check("reset_busy", 32'(row_busy), 0);
        check("reset_occ", 32'(occupancy), 0);
        disp_fu = 0; #1;
        check("ok_free_row", 32'(disp_ok), 1);
        disp_fu = 3; #1;
        check("ok_fu_out_of_range", 32'(disp_ok), 0);

        disp(1, 4, 1, 0, 0); tick();
        check("disp1_busy", 32'(row_busy), 32'b010);
        check("disp1_ready", 32'(row_ready), 0);
        check("disp1_t1", 32'(row_t1[1*TAG_W +: TAG_W]), 1);

        wb_en = 1; wb_tag = 1; tick();
        check("wake_t1", 32'(row_t1[1*TAG_W +: TAG_W]), 0);
        check("wake_ready", 32'(row_ready), 32'b010);

        disp(2, 7, 3, 0, 0); wb_en = 1; wb_tag = 3; tick();
        check("bypass_t1", 32'(row_t1[2*TAG_W +: TAG_W]), 0);
        check("bypass_ready", 32'(row_ready), 32'b110);
        check("bypass_occ", 32'(occupancy), 2);

        issue_en = 1; issue_fu = 1; tick();
        check("issue_ready", 32'(row_ready), 32'b100);

        disp(0, 2, 0, 2, 0); tick();
        check("fill_busy", 32'(row_busy), 32'b111);
        check("fill_occ", 32'(occupancy), 3);
        issue_en = 1; issue_fu = 0; tick();
        check("issue_notready", 32'(row_ready), 32'b100);
        wb_en = 1; wb_tag = 2; tick();
        check("wake_t2", 32'(row_ready), 32'b101);

        disp(0, 11, 0, 0, 0); #1;
        check("collide_ok", 32'(disp_ok), 0);
        tick();
        check("collide_rd", 32'(row_rd[0 +: REG_W]), 2);
        disp(0, 11, 0, 0, 0); done_en = 1; done_fu = 0; #1;
        check("done_disp_ok", 32'(disp_ok), 0);
        tick();
        check("done_busy", 32'(row_busy), 32'b110);
        check("done_occ", 32'(occupancy), 2);
        disp(0, 11, 0, 0, 0); #1;
        check("redisp_ok", 32'(disp_ok), 1);
        tick();
        check("redisp_rd", 32'(row_rd[0 +: REG_W]), 11);

        for (int r = 0; r < N; r++) begin
            done_en = 1; done_fu = FU_W'(r); tick();
        end
        check("drain_busy", 32'(row_busy), 0);

        disp(0, 1, 3, 0, 0); tick();
        disp(1, 2, 0, 0, 1); tick();
        disp(2, 3, 0, 0, 1); tick();
        check("spec_ready", 32'(row_ready), 32'b110);
        flush = 1; wb_en = 1; wb_tag = 3; tick();
        check("flush_busy", 32'(row_busy), 32'b001);
        check("flush_occ", 32'(occupancy), 1);
        check("flush_wake_t1", 32'(row_t1[0 +: TAG_W]), 0);
        check("flush_ready", 32'(row_ready), 32'b001);
        disp(1, 9, 0, 0, 0); flush = 1; #1;
        check("flush_ok", 32'(disp_ok), 0);
        tick();
        check("flush_drop", 32'(row_busy), 32'b001);

        disp(1, 5, 0, 0, 1); tick();
        flush = 1; resolved = 1; tick();
        check("flush_wins", 32'(row_busy), 32'b001);

        disp(1, 5, 0, 0, 1); tick();
        disp(2, 6, 0, 0, 1); resolved = 1; tick();
        check("resolved_busy", 32'(row_busy), 32'b111);
        flush = 1; tick();
        check("resolved_keep", 32'(row_busy), 32'b011);
        check("resolved_occ", 32'(occupancy), 2);

        disp(2, 8, 1, 1, 0); tick();
        check("refill_busy", 32'(row_busy), 32'b111);
        #1 nRST = 0;
        #1;
        check("async_busy", 32'(row_busy), 0);
        check("async_occ", 32'(occupancy), 0);
        check("async_rd", 32'(row_rd), 0);
        @(posedge CLK);
        #2 nRST = 1;
        disp(1, 3, 0, 0, 0); tick();
        check("post_reset_busy", 32'(row_busy), 32'b010);
        repeat (2) tick();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
